// File: rtl/pixel_group_serializer_if.sv
// Handshake bundle between the shape drawer, the pixel group serializer and the addressing engine.
// master = traffic source/sink side, slave = serializer side.
interface pixel_group_serializer_if #(
    parameter int unsigned NUM_PX  = 4,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 12
) ();
    logic [NUM_PX*COORD_W-1:0]    in_x;
    logic [NUM_PX*COORD_W-1:0]    in_y;
    logic [COLOR_W-1:0]           in_color;
    logic [NUM_PX-1:0]            in_mask;
    logic                         in_rts;
    logic                         in_rtr;
    logic [2*COORD_W+COLOR_W-1:0] out_data;
    logic                         out_rts;
    logic                         out_rtr;

    modport master (
        output in_x, in_y, in_color, in_mask, in_rts, out_rtr,
        input  in_rtr, out_data, out_rts
    );

    modport slave (
        input  in_x, in_y, in_color, in_mask, in_rts, out_rtr,
        output in_rtr, out_data, out_rts
    );
endinterface

// File: rtl/pixel_group_serializer.sv
// Clips/masks a group of NUM_PX shared-colour pixels and serializes survivors into a show-ahead FIFO.
// Optional macro PXSER_DEDUP_EN: also drop lanes duplicating a lower kept-eligible lane of the same group.
module pixel_group_serializer #(
    parameter int unsigned NUM_PX    = 4,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned COLOR_W   = 12,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned LOG2DEPTH = 7,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MAX     = 479
) (
    input  logic                   clk,
    input  logic                   rst_,
    pixel_group_serializer_if.slave bus,
    output logic [LOG2DEPTH:0]     fill,
    output logic [15:0]            drop_cnt
);
    localparam int unsigned WORD_W = 2*COORD_W + COLOR_W;
    localparam int unsigned IDX_W  = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;
    localparam int unsigned FILL_W = LOG2DEPTH + 1;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                    r_state;
    logic [NUM_PX*COORD_W-1:0] r_x;
    logic [NUM_PX*COORD_W-1:0] r_y;
    logic [COLOR_W-1:0]        r_color;
    logic [NUM_PX-1:0]         r_mask;
    logic [IDX_W-1:0]          r_idx;
    logic [WORD_W-1:0]         r_mem [DEPTH];
    logic [LOG2DEPTH-1:0]      r_wr_ptr;
    logic [LOG2DEPTH-1:0]      r_rd_ptr;
    logic [FILL_W-1:0]         r_fill;
    logic [15:0]               r_drop_cnt;

    logic [COORD_W-1:0] w_lx [NUM_PX];
    logic [COORD_W-1:0] w_ly [NUM_PX];
    logic [NUM_PX-1:0]  w_inb;
    logic [COORD_W-1:0] w_cur_x;
    logic [COORD_W-1:0] w_cur_y;
    logic               w_dup;
    logic               w_valid;
    logic               w_keep;
    logic               w_drop;
    logic               w_wr;
    logic               w_rd;
    logic               w_room;
    logic               w_in_rtr;
    logic               w_accept;

    // Unpack held lanes and evaluate visibility for every lane
    always_comb begin
        for (int i = 0; i < int'(NUM_PX); i++) begin
            w_lx[i]  = r_x[i*COORD_W +: COORD_W];
            w_ly[i]  = r_y[i*COORD_W +: COORD_W];
            w_inb[i] = (w_lx[i] <= COORD_W'(X_MAX)) && (w_ly[i] <= COORD_W'(Y_MAX));
        end
    end

    assign w_cur_x = w_lx[r_idx];
    assign w_cur_y = w_ly[r_idx];

`ifdef PXSER_DEDUP_EN
    // A lane repeats an earlier visible lane's pixel, e.g. at an ellipse apex
    always_comb begin
        w_dup = 1'b0;
        for (int j = 0; j < int'(NUM_PX); j++) begin
            if ((IDX_W'(j) < r_idx) && r_mask[j] && w_inb[j] &&
                (w_lx[j] == w_cur_x) && (w_ly[j] == w_cur_y)) begin
                w_dup = 1'b1;
            end
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_valid  = (r_state == S_EMIT) && r_mask[r_idx];
    assign w_keep   = w_valid && w_inb[r_idx] && !w_dup;
    assign w_drop   = w_valid && !w_keep;
    assign w_wr     = w_keep;
    assign w_rd     = (r_fill != '0) && bus.out_rtr;
    // Room for a full group guarantees EMIT never overflows the FIFO
    assign w_room   = (r_fill <= FILL_W'(DEPTH - NUM_PX));
    assign w_in_rtr = !rst_ && (r_state == S_IDLE) && w_room;
    assign w_accept = bus.in_rts && w_in_rtr;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_mask     <= '0;
            r_idx      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= bus.in_x;
                        r_y     <= bus.in_y;
                        r_color <= bus.in_color;
                        r_mask  <= bus.in_mask;
                        r_idx   <= '0;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (r_idx == IDX_W'(NUM_PX - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_wr) r_wr_ptr <= r_wr_ptr + LOG2DEPTH'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + LOG2DEPTH'(1);
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase

            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by r_fill
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_cur_x, w_cur_y, r_color};
    end

    assign bus.in_rtr   = w_in_rtr;
    assign bus.out_rts  = (r_fill != '0);
    assign bus.out_data = (r_fill != '0) ? r_mem[r_rd_ptr] : '0;
    assign fill         = r_fill;
    assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_pixel_group_serializer.sv
// Directed + randomized bench for pixel_group_serializer against a per-group reference model.
module tb_pixel_group_serializer;
    logic        clk;
    logic        rst_;
    logic [7:0]  fill;
    logic [15:0] drop_cnt;

    pixel_group_serializer_if #(.NUM_PX(4), .COORD_W(10), .COLOR_W(12)) bus ();

    pixel_group_serializer dut (
        .clk      (clk),
        .rst_     (rst_),
        .bus      (bus.slave),
        .fill     (fill),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          words_seen;
    int unsigned model_drops;
    logic [31:0] exp_q [$];
    logic        last_accept;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected surviving words and drop count of one accepted group
    task automatic model_group(input logic [39:0] xs, input logic [39:0] ys,
                               input logic [11:0] c, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            int  xi;
            int  yi;
            bit  vis;
            bit  dup;
            xi  = int'(xs[i*10 +: 10]);
            yi  = int'(ys[i*10 +: 10]);
            vis = (xi <= 639) && (yi <= 479);
            dup = 1'b0;
`ifdef PXSER_DEDUP_EN
            for (int j = 0; j < i; j++) begin
                if (m[j] && int'(xs[j*10 +: 10]) <= 639 && int'(ys[j*10 +: 10]) <= 479 &&
                    int'(xs[j*10 +: 10]) == xi && int'(ys[j*10 +: 10]) == yi) dup = 1'b1;
            end
`endif
            if (m[i] && vis && !dup) exp_q.push_back({xs[i*10 +: 10], ys[i*10 +: 10], c});
            else if (m[i]) model_drops++;
        end
    endtask

    // One clock: settle, score output transfer, model input transfer, advance to edge+1
    task automatic tick();
        #1;
        last_accept = 1'b0;
        if (rst_) begin
            exp_q.delete();
            model_drops = 0;
        end else begin
            if (bus.out_rts && bus.out_rtr) begin
                if (exp_q.size() == 0) chk("spurious_word", 64'(bus.out_rts), 64'd0);
                else begin
                    chk("word", 64'(bus.out_data), 64'(exp_q.pop_front()));
                    words_seen++;
                end
            end
            if (bus.in_rts && bus.in_rtr) begin
                last_accept = 1'b1;
                model_group(bus.in_x, bus.in_y, bus.in_color, bus.in_mask);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_       = 1'b1;
        bus.in_rts = 1'b0;
        #1;
        chk("rtr_in_reset", 64'(bus.in_rtr), 64'd0);
        tick();
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_out_rts", 64'(bus.out_rts), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_ = 1'b0;
    endtask

    task automatic set_lane(input int i, input int x, input int y);
        bus.in_x[i*10 +: 10] = 10'(x);
        bus.in_y[i*10 +: 10] = 10'(y);
    endtask

    task automatic drain(input int budget);
        int n;
        bus.in_rts  = 1'b0;
        bus.out_rtr = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (6) tick();
        chk("drain_fill", 64'(fill), 64'd0);
        chk("drain_out_rts", 64'(bus.out_rts), 64'd0);
    endtask

    initial begin
        int w0;
        int n;
        vectors      = 0;
        miscompares  = 0;
        words_seen   = 0;
        model_drops  = 0;
        rst_         = 1'b1;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_color = '0;
        bus.in_mask  = '0;
        bus.in_rts   = 1'b0;
        bus.out_rtr  = 1'b1;
        @(posedge clk);
        #1;

        // Basic group, lane order and latency
        do_reset();
        #1;
        chk("t1_rtr_idle", 64'(bus.in_rtr), 64'd1);
        set_lane(0, 10, 20); set_lane(1, 30, 20); set_lane(2, 10, 40); set_lane(3, 30, 40);
        bus.in_color = 12'hF00; bus.in_mask = 4'hF; bus.in_rts = 1'b1; bus.out_rtr = 1'b1;
        w0 = words_seen;
        tick();
        chk("t1_accept", 64'(last_accept), 64'd1);
        bus.in_rts = 1'b0;
        chk("t1_lat0", 64'(bus.out_rts), 64'd0);
        tick();
        chk("t1_lat1", 64'(bus.out_rts), 64'd1);
        chk("t1_head", 64'(bus.out_data), 64'({10'd10, 10'd20, 12'hF00}));
        drain(40);
        chk("t1_words", 64'(words_seen - w0), 64'd4);
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // Masked lanes and group spacing
        do_reset();
        bus.in_mask = 4'b0101; bus.in_rts = 1'b1;
        w0 = words_seen;
        tick();
        chk("t2_accept", 64'(last_accept), 64'd1);
        bus.in_rts = 1'b0;
        n = 1;
        while (!bus.in_rtr && n < 20) begin
            tick();
            n++;
        end
        chk("t2_rtr_gap", 64'(n), 64'd5);
        drain(40);
        chk("t2_words", 64'(words_seen - w0), 64'd2);
        chk("t2_drop", 64'(drop_cnt), 64'd0);

        // Clipping on both axes at the first invisible coordinate
        do_reset();
        set_lane(0, 10, 20); set_lane(1, 640, 20); set_lane(2, 10, 40); set_lane(3, 30, 480);
        bus.in_mask = 4'hF; bus.in_rts = 1'b1;
        w0 = words_seen;
        tick();
        drain(40);
        chk("t3_words", 64'(words_seen - w0), 64'd2);
        chk("t3_drop", 64'(drop_cnt), 64'd2);

        // Degenerate ellipse: all four lanes at one pixel
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 100, 100);
        bus.in_mask = 4'hF; bus.in_rts = 1'b1;
        w0 = words_seen;
        tick();
        drain(40);
`ifdef PXSER_DEDUP_EN
        chk("t4_words", 64'(words_seen - w0), 64'd1);
        chk("t4_drop", 64'(drop_cnt), 64'd3);
`else
        chk("t4_words", 64'(words_seen - w0), 64'd4);
        chk("t4_drop", 64'(drop_cnt), 64'd0);
`endif

        // Back-pressure until the FIFO is full, then release
        do_reset();
        bus.out_rtr = 1'b0; bus.in_mask = 4'hF;
        for (int k = 0; k < 200; k++) begin
            int bx;
            bx = int'($urandom_range(0, 635));
            for (int i = 0; i < 4; i++) set_lane(i, bx + i, int'($urandom_range(0, 479)));
            bus.in_color = 12'($urandom);
            bus.in_rts   = 1'b1;
            #1;
            if (fill > 8'd124) chk("t5_rtr_full", 64'(bus.in_rtr), 64'd0);
            tick();
        end
        bus.in_rts = 1'b0;
        repeat (6) tick();
        chk("t5_fill", 64'(fill), 64'd128);
        chk("t5_model_fill", 64'(fill), 64'(exp_q.size()));
        w0 = words_seen;
        drain(300);
        chk("t5_words", 64'(words_seen - w0), 64'd128);

        // Reset while lane 2 is being processed
        do_reset();
        bus.out_rtr = 1'b0;
        for (int i = 0; i < 4; i++) set_lane(i, 200 + i, 300);
        bus.in_mask = 4'hF; bus.in_rts = 1'b1;
        tick();
        bus.in_rts = 1'b0;
        tick();
        tick();
        chk("t6_pre_fill", 64'(fill), 64'd2);
        do_reset();
        bus.out_rtr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_no_emit", 64'(bus.out_rts), 64'd0);
        end

        // Randomized traffic with clips, masks, duplicates and back-pressure
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) set_lane(i, 100, 100);
                else set_lane(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
            end
            bus.in_mask  = 4'($urandom);
            bus.in_color = 12'($urandom);
            bus.in_rts   = 1'($urandom);
            bus.out_rtr  = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(400);
        chk("rand_drop", 64'(drop_cnt), 64'(model_drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
